// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - per-channel button synchronizer, debounce FSM and long-press timer
module button_debouncer #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 12000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] BTN,
  output logic [N_BTN-1:0] PRESSED,
  output logic [N_BTN-1:0] PRESS_PULSE,
  output logic [N_BTN-1:0] RELEASE_PULSE,
  output logic [N_BTN-1:0] LONG_PULSE
);

  // One counter serves both the debounce window and the long-press timer,
  // so it is sized for whichever of the two is longer.
  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > LONG_CYCLES) ? DEBOUNCE_CYCLES : LONG_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] LONG_LAST = (LONG_CYCLES == 0) ? '0 : CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT   = '1;
  localparam bit            LONG_EN   = (LONG_CYCLES != 0);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    LONG_HELD,
    RELEASE_WAIT
  } state_t;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic          sync1;
    logic          sync2;
    logic          act;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          long_flag;
    logic          pressed_r;
    logic          press_r;
    logic          release_r;
    logic          long_r;

    // Normalise the synchronized pin so that 1 always means pressed.
    assign act = sync2 ^ ACTIVE_LOW;

    // Saturating increment: the counter must never wrap, even when the
    // long-press timer is disabled and a button is held indefinitely.
    assign cnt_inc = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

    // Synchronizer, debounce/long-press FSM and registered outputs for one channel.
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        sync1     <= ACTIVE_LOW;
        sync2     <= ACTIVE_LOW;
        state     <= IDLE;
        cnt       <= '0;
        long_flag <= 1'b0;
        pressed_r <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
      end else begin
        sync1     <= BTN[i];
        sync2     <= sync1;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
        case (state)
          IDLE: begin
            if (act) begin
              state <= PRESS_WAIT;
              cnt   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!act) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == DEB_LAST) begin
              state     <= HELD;
              cnt       <= '0;
              pressed_r <= 1'b1;
              press_r   <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          HELD: begin
            if (!act) begin
              state <= RELEASE_WAIT;
              cnt   <= '0;
            end else if (LONG_EN && cnt == LONG_LAST) begin
              state  <= LONG_HELD;
              cnt    <= '0;
              long_r <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          LONG_HELD: begin
            if (!act) begin
              state     <= RELEASE_WAIT;
              cnt       <= '0;
              long_flag <= 1'b1;
            end
          end
          RELEASE_WAIT: begin
            // A bounce during release resumes the held state silently; the
            // long flag keeps a bounce from re-arming the long-press pulse.
            if (act) begin
              state <= long_flag ? LONG_HELD : HELD;
              cnt   <= '0;
            end else if (cnt == DEB_LAST) begin
              state     <= IDLE;
              cnt       <= '0;
              pressed_r <= 1'b0;
              release_r <= 1'b1;
              long_flag <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign PRESSED[i]       = pressed_r;
    assign PRESS_PULSE[i]   = press_r;
    assign RELEASE_PULSE[i] = release_r;
    assign LONG_PULSE[i]    = long_r;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - randomized and directed bench for button_debouncer against a run-length model
module tb_button_debouncer;

  localparam int N = 4;
  localparam int D = 4;
  localparam int L = 10;

  logic         CLK = 1'b0;
  logic         RST;
  logic [N-1:0] BTN;
  logic [N-1:0] PRESSED;
  logic [N-1:0] PRESS_PULSE;
  logic [N-1:0] RELEASE_PULSE;
  logic [N-1:0] LONG_PULSE;

  int n_cmp = 0;
  int n_bad = 0;

  button_debouncer #(
    .N_BTN(N),
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .BTN(BTN),
    .PRESSED(PRESSED),
    .PRESS_PULSE(PRESS_PULSE),
    .RELEASE_PULSE(RELEASE_PULSE),
    .LONG_PULSE(LONG_PULSE)
  );

  always #5 CLK = ~CLK;

  // Reference model: a press is accepted once act has been 1 on D+1
  // consecutive edges while released (release: D+1 consecutive 0s while
  // pressed); the long pulse fires after L further edges of act=1 counted
  // from acceptance or from the last release bounce. The pin reaches the
  // decision logic two edges late.
  logic [N-1:0] pin_q[$];
  logic [N-1:0] m_pressed;
  logic [N-1:0] m_pp;
  logic [N-1:0] m_rp;
  logic [N-1:0] m_lp;
  int           m_run[N];
  int           m_hold[N];
  bit           m_long[N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    pin_q.delete();
    pin_q.push_back('1);
    pin_q.push_back('1);
    m_pressed = '0;
    m_pp = '0;
    m_rp = '0;
    m_lp = '0;
    for (int c = 0; c < N; c++) begin
      m_run[c]  = 0;
      m_hold[c] = 0;
      m_long[c] = 1'b0;
    end
  endtask

  task automatic model_edge(input logic [N-1:0] pin);
    logic [N-1:0] act;
    act = ~pin_q.pop_front();
    pin_q.push_back(pin);
    m_pp = '0;
    m_rp = '0;
    m_lp = '0;
    for (int c = 0; c < N; c++) begin
      if (!m_pressed[c]) begin
        if (act[c]) begin
          m_run[c]++;
          if (m_run[c] == D + 1) begin
            m_pressed[c] = 1'b1;
            m_pp[c]      = 1'b1;
            m_run[c]     = 0;
            m_hold[c]    = 0;
            m_long[c]    = 1'b0;
          end
        end else begin
          m_run[c] = 0;
        end
      end else if (!act[c]) begin
        m_run[c]++;
        if (m_run[c] == D + 1) begin
          m_pressed[c] = 1'b0;
          m_rp[c]      = 1'b1;
          m_run[c]     = 0;
        end
      end else if (m_run[c] > 0) begin
        m_run[c]  = 0;
        m_hold[c] = 0;
      end else if (!m_long[c]) begin
        m_hold[c]++;
        if (m_hold[c] == L) begin
          m_lp[c]   = 1'b1;
          m_long[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge(BTN);
    #1;
    check("pressed", PRESSED, m_pressed);
    check("press_pulse", PRESS_PULSE, m_pp);
    check("release_pulse", RELEASE_PULSE, m_rp);
    check("long_pulse", LONG_PULSE, m_lp);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  int pe;
  int le;
  int re;
  int n_pp;
  int n_rp;
  int seg[N];
  logic [N-1:0] seen;

  initial begin
    model_reset();
    RST = 1'b1;
    BTN = '1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_pressed", PRESSED, 0);
    check("rst_press_pulse", PRESS_PULSE, 0);
    check("rst_release_pulse", RELEASE_PULSE, 0);
    check("rst_long_pulse", LONG_PULSE, 0);
    RST = 1'b0;

    // Clean press on channel 0: pulse after edge 7, others quiet.
    BTN = 4'b1110;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check("clean_press_pulse", PRESS_PULSE, (e == 7) ? 4'b0001 : 4'b0000);
      check("clean_pressed", PRESSED, (e >= 7) ? 4'b0001 : 4'b0000);
    end
    BTN = '1;
    ticks(10);

    // Bounce rejection on channel 1.
    seen = '0;
    for (int i = 0; i < 20; i++) begin
      BTN[1] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      seen |= PRESSED | PRESS_PULSE | RELEASE_PULSE | LONG_PULSE;
    end
    BTN[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= PRESSED | PRESS_PULSE | RELEASE_PULSE | LONG_PULSE;
    end
    check("bounce_quiet", seen, 0);

    // Long press and release on channel 2.
    pe = -1;
    le = -1;
    BTN[2] = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (PRESS_PULSE[2]) pe = e;
      if (LONG_PULSE[2]) le = e;
    end
    check("long_press_edge", pe, 7);
    check("long_pulse_edge", le, 17);
    re = -1;
    BTN[2] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (RELEASE_PULSE[2]) begin
        re = e;
        check("release_drops_pressed", PRESSED[2], 0);
      end
    end
    check("release_edge", re, 7);

    // Release bounce on channel 3.
    n_pp = 0;
    n_rp = 0;
    BTN[3] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) BTN[3] = 1'b1;
      if (i == 12) BTN[3] = 1'b0;
      if (i == 17) BTN[3] = 1'b1;
      tick();
      n_pp += int'(PRESS_PULSE[3]);
      n_rp += int'(RELEASE_PULSE[3]);
    end
    check("rel_bounce_press_count", n_pp, 1);
    check("rel_bounce_release_count", n_rp, 1);

    // Simultaneous presses on channels 0 and 3.
    BTN = 4'b0110;
    for (int e = 1; e <= 8; e++) begin
      tick();
      check("simul_press_pulse", PRESS_PULSE, (e == 7) ? 4'b1001 : 4'b0000);
    end
    BTN = '1;
    ticks(10);

    // Asynchronous reset while channel 2 is held.
    BTN[2] = 1'b0;
    ticks(10);
    #3;
    RST = 1'b1;
    #1;
    check("async_rst_pressed", PRESSED, 0);
    check("async_rst_pulses", PRESS_PULSE | RELEASE_PULSE | LONG_PULSE, 0);
    model_reset();
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
    pe = -1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      if (PRESS_PULSE[2]) pe = e;
    end
    check("post_rst_press_edge", pe, 7);
    BTN = '1;
    ticks(10);

    // Randomized segments: short bounces mixed with long stable holds.
    for (int c = 0; c < N; c++) seg[c] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        if (seg[c] == 0) begin
          BTN[c] = 1'($urandom_range(0, 1));
          seg[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(4, 30));
        end
        seg[c]--;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Input-side companion to the LED output logic on the 12 MHz board: conditions the raw push-button pins into clean, glitch-free signals.
- Per channel: 2-flop synchronizer, debounce state machine, long-press timer.
- Outputs are a debounced level plus single-cycle press, release and long-press pulses for downstream control logic.
- Channels are fully independent.

Parameters:
- N_BTN, 4, number of button channels.
- DEBOUNCE_CYCLES, 240000, stable cycles required to accept a transition (20 ms at 12 MHz); must be >= 1.
- LONG_CYCLES, 12000000, cycles held after an accepted press before the long-press pulse (1 s); 0 disables long-press detection.
- ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; 0 = reads 1 when pressed.

Ports:
- CLK  in  1  system clock, 12 MHz.
- RST  in  1  asynchronous, active-high reset.
- BTN  in  N_BTN  raw, asynchronous button pins.
- PRESSED  out  N_BTN  debounced pressed level, 1 = pressed.
- PRESS_PULSE  out  N_BTN  1-cycle pulse on an accepted press.
- RELEASE_PULSE  out  N_BTN  1-cycle pulse on an accepted release.
- LONG_PULSE  out  N_BTN  1-cycle pulse when a press has lasted LONG_CYCLES.

Behaviour:
- Reset: asynchronous, active-high.
  - All outputs go to 0, all FSMs to IDLE, all counters to 0.
  - Synchronizer flops load the inactive pin level (1 if ACTIVE_LOW).
  - A button held through reset release is detected as a fresh press after normal latency.
- Synchronizer: 2 flops per channel. act = synchronized pin XOR ACTIVE_LOW, normalised so 1 = pressed.
- Counter: one per channel, width $clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES)+1). It never wraps; it is cleared on every state change.
- FSM per channel (all outputs registered):
  - IDLE: if act=1, go to PRESS_WAIT with cnt=0.
  - PRESS_WAIT:
    - act=0: back to IDLE, no pulse.
    - act=1 and cnt==DEBOUNCE_CYCLES-1: go to HELD; PRESSED<=1; PRESS_PULSE<=1 for one cycle.
    - Otherwise: cnt+1.
  - HELD:
    - act=0: go to RELEASE_WAIT, cnt=0.
    - LONG_CYCLES!=0 and act=1 and cnt==LONG_CYCLES-1: go to LONG_HELD; LONG_PULSE<=1 for one cycle.
    - Otherwise: cnt+1.
  - LONG_HELD:
    - act=0: go to RELEASE_WAIT, cnt=0, and set the long flag.
    - Otherwise: stay; no further long pulses.
  - RELEASE_WAIT:
    - PRESSED stays 1 throughout.
    - act=1 (bounce): return to LONG_HELD if the long flag is set, else to HELD with cnt=0; no pulse in either case.
    - act=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE; PRESSED<=0; RELEASE_PULSE<=1 for one cycle; long flag cleared.
    - Otherwise: cnt+1.
- Latency:
  - Raw pin becomes active before edge 1.
  - act is seen at edge 3 (IDLE to PRESS_WAIT).
  - PRESSED/PRESS_PULSE go high after edge DEBOUNCE_CYCLES+3.
  - Release latency is identical.
- Pulse rules:
  - Every pulse is exactly 1 cycle wide.
  - Press, long and release pulses never coincide on one channel.
  - Different channels may pulse in the same cycle.
  - PRESS_PULSE and RELEASE_PULSE strictly alternate per channel.
- With DEBOUNCE_CYCLES=1, a single-cycle glitch still passes through IDLE to PRESS_WAIT, and is rejected if act=0 on the next edge.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW=1, N_BTN=4):
- Clean press: BTN[0] driven 1 to 0 and held → PRESSED[0]=1 and PRESS_PULSE[0] high for exactly 1 cycle after edge 7; other channels stay 0.
- Bounce rejection: BTN[1] toggles 0/1 every 2 cycles for 20 cycles, then returns to 1 → no pulses, PRESSED[1]=0 throughout.
- Long press and release:
  - BTN[2] held low 30 cycles, then released → PRESS_PULSE at edge 7, LONG_PULSE exactly 10 cycles later (edge 17).
  - RELEASE_PULSE 7 cycles after release; PRESSED[2] drops in the same cycle as RELEASE_PULSE.
- Release bounce: with BTN[3] held, release for 2 cycles, press again, then release cleanly → no RELEASE_PULSE for the 2-cycle release and no second PRESS_PULSE; a single RELEASE_PULSE after the clean release.
- Simultaneous channels: BTN[0] and BTN[3] pressed in the same cycle → both PRESS_PULSE bits high in the same cycle (edge 7).
- Reset mid-operation: assert RST asynchronously in HELD, between clock edges → all outputs 0 immediately; with BTN still held after RST drops, a new PRESS_PULSE arrives 7 edges later.
